fetch_unit: RTL and testbench

//   Instruction fetch stage; the producer for the instruction queue. Keeps the PC, issues one
//   32-bit read at a time to instruction memory, and pushes {pc, instr} into the queue.

---
 rtl/fetch_if.sv | 21 ++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, instruction-queue and redirect signals seen by the fetch stage.
interface fetch_if #(parameter int XLEN = 32);
  logic [XLEN-1:0]   imem_addr;
  logic [3:0]        imem_rmask;
  logic [XLEN-1:0]   imem_rdata;
  logic              imem_resp;
  logic              q_enqueue;
  logic [2*XLEN-1:0] q_wdata;
  logic              q_full;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic [XLEN-1:0]   fetch_pc;
  modport master (
    output imem_addr, imem_rmask, q_enqueue, q_wdata, fetch_pc,
    input  imem_rdata, imem_resp, q_full, redirect, redirect_pc
  );
  modport slave (
    input  imem_addr, imem_rmask, q_enqueue, q_wdata, fetch_pc,
    output imem_rdata, imem_resp, q_full, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC keeper issuing one imem read at a time and pushing {pc, instr} into the
// instruction queue, with a one-entry hold for backpressure and discard of redirected fetches.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, hold_q, hold_d;
  logic            discard_q, discard_d, enq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ISSUE;
      pc_q      <= RESET_PC;
      hold_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      discard_q <= discard_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    discard_d = discard_q;
    enq       = 1'b0;
    if (bus.redirect) begin
      // an outstanding request with no response yet must be dropped when it returns
      pc_d      = {bus.redirect_pc[XLEN-1:2], 2'b00};
      discard_d = state_q == S_WAIT && !bus.imem_resp;
      state_d   = discard_d ? S_WAIT : S_ISSUE;
    end else begin
      unique case (state_q)
        S_ISSUE: state_d = bus.q_full ? S_ISSUE : S_WAIT;
        S_WAIT: begin
          if (bus.imem_resp) begin
            discard_d = 1'b0;
            if (discard_q) begin
              state_d = S_ISSUE;
            end else if (!bus.q_full) begin
              enq     = 1'b1;
              pc_d    = pc_q + XLEN'(4);
              state_d = S_ISSUE;
            end else begin
              hold_d  = bus.imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.q_full) begin
            enq     = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            state_d = S_ISSUE;
          end
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end
  assign bus.imem_addr  = pc_q;
  assign bus.imem_rmask = (rst_n && state_q == S_ISSUE && !bus.redirect && !bus.q_full) ? 4'hF : 4'h0;
  assign bus.q_enqueue  = enq;
  assign bus.q_wdata    = {pc_q, state_q == S_HOLD ? hold_q : bus.imem_rdata};
  assign bus.fetch_pc   = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetch sequences plus hand-written redirect/reset corners,
// with a queue scoreboard checking every push the DUT makes.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h1eceb000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  fetch_if #(.XLEN(32)) bus();
  fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        do_redir;
    logic [31:0] rpc;
    logic [31:0] instr;
    int          lat;
    int          full;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl[7];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  always begin
    @(negedge clk);
    #4;
    if (bus.q_enqueue === 1'b1) begin
      if (sb.size() == 0) check("unexpected_push", bus.q_wdata, 64'hx);
      else check("push_data", bus.q_wdata, sb.pop_front());
    end
  end
  task automatic issue(input logic [31:0] a);
    bus.q_full = 1'b0;
    #1;
    check("req_rmask", 64'(bus.imem_rmask), 64'hF);
    check("req_addr", 64'(bus.imem_addr), 64'(a));
    step();
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] instr, input int lat, input int full);
    issue(a);
    for (int i = 1; i < lat; i++) begin
      #1 check("wait_idle_rmask", 64'(bus.imem_rmask), 64'h0);
      step();
    end
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = instr;
    bus.q_full     = full > 0;
    if (full == 0) sb.push_back({a, instr});
    #1 check("resp_enq", 64'(bus.q_enqueue), 64'(full == 0));
    step();
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = 32'hbad0bad0;
    if (full > 0) begin
      for (int i = 1; i < full; i++) begin
        #1 check("hold_stall_enq", 64'(bus.q_enqueue), 64'h0);
        check("hold_stall_rmask", 64'(bus.imem_rmask), 64'h0);
        step();
      end
      bus.q_full = 1'b0;
      sb.push_back({a, instr});
      #1 check("hold_release_enq", 64'(bus.q_enqueue), 64'h1);
      step();
    end
  endtask
  initial begin
    tbl[0] = '{1'b0, 32'h0,        32'h00000013, 1, 0, 32'h1eceb000};
    tbl[1] = '{1'b0, 32'h0,        32'h00a00093, 1, 3, 32'h1eceb004};
    tbl[2] = '{1'b0, 32'h0,        32'h00100113, 3, 0, 32'h1eceb008};
    tbl[3] = '{1'b1, 32'h1eceb100, 32'h11111111, 2, 0, 32'h1eceb100};
    tbl[4] = '{1'b0, 32'h0,        32'h22222222, 1, 1, 32'h1eceb104};
    tbl[5] = '{1'b1, 32'hFFFFFFFE, 32'h33333333, 1, 0, 32'hFFFFFFFC};
    tbl[6] = '{1'b0, 32'h0,        32'h44444444, 1, 0, 32'h00000000};
    bus.imem_rdata = '0; bus.imem_resp = 1'b0; bus.q_full = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    @(negedge clk);
    #1 check("rst_rmask", 64'(bus.imem_rmask), 64'h0);
    check("rst_enq", 64'(bus.q_enqueue), 64'h0);
    check("rst_pc", 64'(bus.fetch_pc), 64'(RPC));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      if (tbl[k].do_redir) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = tbl[k].rpc;
        #1 check("redir_issue_rmask", 64'(bus.imem_rmask), 64'h0);
        step();
        bus.redirect = 1'b0;
      end
      fetch(tbl[k].exp_addr, tbl[k].instr, tbl[k].lat, tbl[k].full);
    end
    // redirects while waiting (twice, last wins), response arrives later and is dropped
    issue(32'h00000004);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h1eceb0f0;
    #1 check("redir_wait_enq", 64'(bus.q_enqueue), 64'h0);
    step();
    bus.redirect_pc = 32'h1eceb100;
    step();
    bus.redirect = 1'b0;
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'hdeadbeef;
    #1 check("discard_enq", 64'(bus.q_enqueue), 64'h0);
    step();
    bus.imem_resp = 1'b0;
    fetch(32'h1eceb100, 32'h55555555, 1, 0);
    // redirect in the same cycle as the response
    issue(32'h1eceb104);
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'hdeadbeef;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h1eceb200;
    #1 check("redir_resp_enq", 64'(bus.q_enqueue), 64'h0);
    step();
    bus.imem_resp = 1'b0; bus.redirect = 1'b0;
    fetch(32'h1eceb200, 32'h66666666, 1, 0);
    // redirect while holding data: held instruction is never pushed
    issue(32'h1eceb204);
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'hdeadbeef; bus.q_full = 1'b1;
    step();
    bus.imem_resp = 1'b0; bus.q_full = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h1eceb300;
    #1 check("redir_hold_enq", 64'(bus.q_enqueue), 64'h0);
    step();
    bus.redirect = 1'b0;
    fetch(32'h1eceb300, 32'h77777777, 1, 0);
    // asynchronous reset mid-wait, then a stale response after release
    issue(32'h1eceb304);
    rst_n = 1'b0;
    #1 check("async_rst_rmask", 64'(bus.imem_rmask), 64'h0);
    check("async_rst_enq", 64'(bus.q_enqueue), 64'h0);
    check("async_rst_pc", 64'(bus.fetch_pc), 64'(RPC));
    step();
    rst_n = 1'b1;
    bus.q_full = 1'b1; bus.imem_resp = 1'b1; bus.imem_rdata = 32'hdeadbeef;
    #1 check("late_resp_enq", 64'(bus.q_enqueue), 64'h0);
    check("late_resp_rmask", 64'(bus.imem_rmask), 64'h0);
    step();
    bus.imem_resp = 1'b0;
    fetch(RPC, 32'h88888888, 1, 0);
    step();
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
